// File: rtl/tea_pkg.sv
// Shared constants and types for the TEA core host controller:
// core register map, control codes, FSM state encoding and default word width.
package tea_pkg;

  localparam int TEA_WORD_SIZE = 32;

  localparam logic [3:0] ADDR_DATA0 = 4'd0;
  localparam logic [3:0] ADDR_DATA1 = 4'd1;
  localparam logic [3:0] ADDR_KEY0  = 4'd2;
  localparam logic [3:0] ADDR_KEY1  = 4'd3;
  localparam logic [3:0] ADDR_KEY2  = 4'd4;
  localparam logic [3:0] ADDR_KEY3  = 4'd5;
  localparam logic [3:0] ADDR_CTRL  = 4'd6;
  localparam logic [3:0] ADDR_RES0  = 4'd7;
  localparam logic [3:0] ADDR_RES1  = 4'd8;

  localparam logic [1:0] CTRL_NONE = 2'd0;
  localparam logic [1:0] CTRL_ENC  = 2'd1;
  localparam logic [1:0] CTRL_DEC  = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    READ0     = 3'd4,
    READ1     = 3'd5,
    READ2     = 3'd6,
    RSP       = 3'd7
  } tea_state_e;

endpackage

// File: rtl/tea_host_ctrl.sv
// Host-side sequencer for a register-mapped TEA core: loads data/key/control,
// waits for the core to go busy then idle, reads the result back and returns it.
module tea_host_ctrl
  import tea_pkg::*;
#(
  parameter int WORD_SIZE = TEA_WORD_SIZE,
  parameter int TIMEOUT   = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_mode,
  input  logic [2*WORD_SIZE-1:0] i_req_data,
  input  logic [4*WORD_SIZE-1:0] i_req_key,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [2*WORD_SIZE-1:0] o_rsp_data,
  output logic                   o_rsp_err,
  output logic [3:0]             o_bus_addr,
  output logic [WORD_SIZE-1:0]   o_bus_data,
  output logic                   o_bus_we,
  input  logic [WORD_SIZE-1:0]   i_bus_rdata,
  input  logic                   i_bus_ready,
  output logic [2:0]             o_dbg_state
);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_WRITE     = WRITE;
  localparam logic [2:0] S_WAIT_BUSY = WAIT_BUSY;
  localparam logic [2:0] S_WAIT_DONE = WAIT_DONE;
  localparam logic [2:0] S_READ0     = READ0;
  localparam logic [2:0] S_READ1     = READ1;
  localparam logic [2:0] S_READ2     = READ2;
  localparam logic [2:0] S_RSP       = RSP;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]             state;
  logic [2:0]             wr_idx;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;
  logic                   mode_q;
  logic [2*WORD_SIZE-1:0] data_q;
  logic [4*WORD_SIZE-1:0] key_q;
  logic [2*WORD_SIZE-1:0] res_q;
  logic                   err_q;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the payload holds until taken.
  assign o_req_ready = (state == S_IDLE);
  assign o_rsp_valid = (state == S_RSP);
  assign o_bus_we    = (state == S_WRITE);
  assign o_rsp_data  = res_q;
  assign o_rsp_err   = err_q;
  assign o_dbg_state = state;

  // Saturating so a stuck core can never wrap the timeout back to zero.
  assign cnt_inc = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      wr_idx <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
      key_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            mode_q <= i_req_mode;
            data_q <= i_req_data;
            key_q  <= i_req_key;
            wr_idx <= '0;
            err_q  <= 1'b0;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_idx == 3'd6) begin
            cnt   <= '0;
            state <= S_WAIT_BUSY;
          end else begin
            wr_idx <= wr_idx + 3'd1;
          end
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if ((state == S_WAIT_BUSY) && !i_bus_ready) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if ((state == S_WAIT_DONE) && i_bus_ready) begin
            state <= S_READ0;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            cnt   <= cnt_inc;
            res_q <= '0;
            err_q <= 1'b1;
            state <= S_RSP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_READ0: state <= S_READ1;
        S_READ1: begin
          // Read data lags the address by one cycle: this is the addr-7 word.
          res_q[WORD_SIZE-1:0] <= i_bus_rdata;
          state                <= S_READ2;
        end
        S_READ2: begin
          res_q[2*WORD_SIZE-1:WORD_SIZE] <= i_bus_rdata;
          state                          <= S_RSP;
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            err_q <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_bus_addr = ADDR_DATA0;
    o_bus_data = '0;
    case (state)
      S_WRITE: begin
        case (wr_idx)
          3'd0: begin
            o_bus_addr = ADDR_DATA0;
            o_bus_data = data_q[WORD_SIZE-1:0];
          end
          3'd1: begin
            o_bus_addr = ADDR_DATA1;
            o_bus_data = data_q[2*WORD_SIZE-1:WORD_SIZE];
          end
          3'd2: begin
            o_bus_addr = ADDR_KEY0;
            o_bus_data = key_q[WORD_SIZE-1:0];
          end
          3'd3: begin
            o_bus_addr = ADDR_KEY1;
            o_bus_data = key_q[2*WORD_SIZE-1:WORD_SIZE];
          end
          3'd4: begin
            o_bus_addr = ADDR_KEY2;
            o_bus_data = key_q[3*WORD_SIZE-1:2*WORD_SIZE];
          end
          3'd5: begin
            o_bus_addr = ADDR_KEY3;
            o_bus_data = key_q[4*WORD_SIZE-1:3*WORD_SIZE];
          end
          default: begin
            o_bus_addr = ADDR_CTRL;
            o_bus_data = WORD_SIZE'(mode_q ? CTRL_DEC : CTRL_ENC);
          end
        endcase
      end
      S_READ0: o_bus_addr = ADDR_RES0;
      S_READ1: o_bus_addr = ADDR_RES1;
      default: o_bus_addr = ADDR_DATA0;
    endcase
  end

endmodule

// File: tb/tb_tea_host_ctrl.sv
// Directed bench for tea_host_ctrl with a behavioural TEA core model and a
// scoreboard of expected bus writes and responses.
module tb_tea_host_ctrl;

  localparam int          TO       = 40;
  localparam int          CORE_LAT = 12;
  localparam int          BUDGET   = 500;
  localparam logic [31:0] DELTA    = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req_valid;
  logic         i_req_mode;
  logic [63:0]  i_req_data;
  logic [127:0] i_req_key;
  logic         i_rsp_ready;
  logic [31:0]  i_bus_rdata;
  logic         i_bus_ready;
  logic         o_req_ready;
  logic         o_rsp_valid;
  logic [63:0]  o_rsp_data;
  logic         o_rsp_err;
  logic [3:0]   o_bus_addr;
  logic [31:0]  o_bus_data;
  logic         o_bus_we;
  logic [2:0]   o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [35:0] exp_wr_q[$];
  logic [64:0] exp_rsp_q[$];

  logic        core_stuck;
  int          busy_cnt = 0;
  logic [31:0] cregs [0:15];

  tea_host_ctrl #(.WORD_SIZE(32), .TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_mode (i_req_mode),
    .i_req_data (i_req_data),
    .i_req_key  (i_req_key),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_bus_addr (o_bus_addr),
    .o_bus_data (o_bus_data),
    .o_bus_we   (o_bus_we),
    .i_bus_rdata(i_bus_rdata),
    .i_bus_ready(i_bus_ready),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] tea_fn(input logic dec, input logic [63:0] d,
                                         input logic [127:0] k);
    logic [31:0] v0, v1, sum, k0, k1, k2, k3;
    v0 = d[31:0];
    v1 = d[63:32];
    k0 = k[31:0];
    k1 = k[63:32];
    k2 = k[95:64];
    k3 = k[127:96];
    if (!dec) begin
      sum = 32'd0;
      for (int i = 0; i < 32; i++) begin
        sum = sum + DELTA;
        v0  = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        v1  = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
        v1  = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        v0  = v0 - (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        sum = sum - DELTA;
      end
    end
    return {v1, v0};
  endfunction

  // behavioural TEA core: goes busy on a non-zero ctrl write, result after CORE_LAT
  assign i_bus_ready = (busy_cnt == 0);

  always @(posedge clk) begin
    i_bus_rdata <= cregs[o_bus_addr];
    if (rst) begin
      busy_cnt <= 0;
    end else if (o_bus_we && o_bus_addr == 4'd6 && o_bus_data != 32'd0 && !core_stuck) begin
      busy_cnt <= CORE_LAT;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1)
        {cregs[8], cregs[7]} <= tea_fn(cregs[6] == 32'd2, {cregs[1], cregs[0]},
                                       {cregs[5], cregs[4], cregs[3], cregs[2]});
    end
    if (o_bus_we) cregs[o_bus_addr] <= o_bus_data;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop on every bus write and every response handshake
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_bus_we) begin
        check("wr_expected", 128'(exp_wr_q.size() != 0), 128'd1);
        if (exp_wr_q.size() != 0)
          check("bus_write", 128'({o_bus_addr, o_bus_data}), 128'(exp_wr_q.pop_front()));
      end else begin
        check("bus_data_idle", 128'(o_bus_data), 128'd0);
      end
      if (o_rsp_valid && i_rsp_ready) begin
        check("rsp_expected", 128'(exp_rsp_q.size() != 0), 128'd1);
        if (exp_rsp_q.size() != 0)
          check("rsp", 128'({o_rsp_err, o_rsp_data}), 128'(exp_rsp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic send_req(input logic mode, input logic [63:0] data, input logic [127:0] key,
                          input logic [64:0] exp_rsp, input bit keep_valid, output int waited);
    logic [31:0] wd;
    i_req_valid = 1'b1;
    i_req_mode  = mode;
    i_req_data  = data;
    i_req_key   = key;
    waited = 0;
    while (!o_req_ready && waited < BUDGET) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("req_accept", 128'(waited < BUDGET), 128'd1);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) wd = data[31:0];
      else if (i == 1) wd = data[63:32];
      else if (i < 6) wd = key[(i-2)*32 +: 32];
      else wd = mode ? 32'd2 : 32'd1;
      exp_wr_q.push_back({4'(i), wd});
    end
    exp_rsp_q.push_back(exp_rsp);
    @(posedge clk);
    #1;
    if (!keep_valid) i_req_valid = 1'b0;
  endtask

  task automatic measure(input string tag, input int exp_lat);
    int n;
    int we_run;
    n = 0;
    we_run = 0;
    while (!o_rsp_valid && n < BUDGET) begin
      if (o_bus_we && n < 7) we_run++;
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 128'(n), 128'(exp_lat));
    check("writes_consecutive", 128'(we_run), 128'd7);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || exp_wr_q.size() != 0 || !o_req_ready) && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 128'(n < BUDGET), 128'd1);
  endtask

  initial begin
    logic [63:0]  d;
    logic [127:0] k;
    logic         m;
    int           w;

    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_mode  = 1'b0;
    i_req_data  = '0;
    i_req_key   = '0;
    i_rsp_ready = 1'b1;
    core_stuck  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_req_ready", 128'(o_req_ready), 128'd1);
    check("rst_rsp_valid", 128'(o_rsp_valid), 128'd0);
    check("rst_rsp_err", 128'(o_rsp_err), 128'd0);
    check("rst_rsp_data", 128'(o_rsp_data), 128'd0);
    check("rst_bus_we", 128'(o_bus_we), 128'd0);
    check("rst_bus_addr", 128'(o_bus_addr), 128'd0);
    check("rst_bus_data", 128'(o_bus_data), 128'd0);
    check("rst_state", 128'(o_dbg_state), 128'd0);
    mon_en = 1'b1;

    // known-answer encrypt of zero data under zero key
    send_req(1'b0, 64'd0, 128'd0, {1'b0, 64'h94BAA940_41EA3A0A}, 1'b0, w);
    check("first_write_addr0", 128'({o_bus_we, o_bus_addr}), 128'h10);
    measure("latency_enc", CORE_LAT + 11);
    drain();

    // round trip back to zero
    send_req(1'b1, 64'h94BAA940_41EA3A0A, 128'd0, {1'b0, 64'd0}, 1'b0, w);
    measure("latency_dec", CORE_LAT + 11);
    drain();

    // random data/key, both modes
    for (int t = 0; t < 3; t++) begin
      d = {$urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = 1'($urandom_range(0, 1));
      send_req(m, d, k, {1'b0, tea_fn(m, d, k)}, 1'b0, w);
      measure("latency_rand", CORE_LAT + 11);
      drain();
    end

    // response backpressure
    i_rsp_ready = 1'b0;
    d = {$urandom(), $urandom()};
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_req(1'b0, d, k, {1'b0, tea_fn(1'b0, d, k)}, 1'b0, w);
    measure("latency_bp", CORE_LAT + 11);
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 128'(o_rsp_valid), 128'd1);
      check("bp_rsp_data", 128'(o_rsp_data), 128'(tea_fn(1'b0, d, k)));
      check("bp_req_ready", 128'(o_req_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    i_rsp_ready = 1'b1;
    drain();

    // core never goes busy: timeout with zeroed data
    core_stuck = 1'b1;
    d = {$urandom(), $urandom()};
    send_req(1'b0, d, 128'd5, {1'b1, 64'd0}, 1'b0, w);
    measure("latency_timeout", TO + 7);
    check("timeout_err", 128'(o_rsp_err), 128'd1);
    drain();
    check("err_cleared", 128'(o_rsp_err), 128'd0);
    core_stuck = 1'b0;

    // reset during the 4th write cycle
    d = {$urandom(), $urandom()};
    send_req(1'b0, d, 128'd7, {1'b0, 64'd0}, 1'b0, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_write_addr3", 128'({o_bus_we, o_bus_addr}), 128'h13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_bus_we", 128'(o_bus_we), 128'd0);
    check("midrst_req_ready", 128'(o_req_ready), 128'd1);
    check("midrst_state", 128'(o_dbg_state), 128'd0);
    check("midrst_writes_left", 128'(exp_wr_q.size()), 128'd3);
    exp_wr_q.delete();
    exp_rsp_q.delete();
    d = {$urandom(), $urandom()};
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_req(1'b0, d, k, {1'b0, tea_fn(1'b0, d, k)}, 1'b0, w);
    measure("latency_after_rst", CORE_LAT + 11);
    drain();

    // back-to-back with request valid held high
    d = {$urandom(), $urandom()};
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_req(1'b0, d, k, {1'b0, tea_fn(1'b0, d, k)}, 1'b1, w);
    d = {$urandom(), $urandom()};
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_req(1'b1, d, k, {1'b0, tea_fn(1'b1, d, k)}, 1'b0, w);
    check("b2b_accept_gap", 128'(w), 128'(CORE_LAT + 12));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tea_host_ctrl.md
TEA_HOST_CTRL -- requirements
Module: tea_host_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning the width of the TEA core register word.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in WAIT_BUSY or WAIT_DONE.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports: i_clk input 1 is the clock; i_rst input 1 is the synchronous active-high reset.
REQ-004 SHALL have i_req_valid input 1, a request strobe.
REQ-005 SHALL have o_req_ready output 1; a request is accepted when valid and ready are both high.
REQ-006 SHALL have i_req_mode input 1; 0 selects encrypt, 1 selects decrypt.
REQ-007 SHALL have i_req_data input 2*WORD_SIZE; [W-1:0] is data part 1, the upper half is part 2.
REQ-008 SHALL have i_req_key input 4*WORD_SIZE; [W-1:0] is key part 1, ascending to part 4.
REQ-009 SHALL have o_rsp_valid output 1, the result strobe.
REQ-010 SHALL have i_rsp_ready input 1, the result accept.
REQ-011 SHALL have o_rsp_data output 2*WORD_SIZE; [W-1:0] is result part 1.
REQ-012 SHALL have o_rsp_err output 1, a timeout flag, valid with o_rsp_valid.
REQ-013 SHALL have o_bus_addr output 4, the TEA core register address.
REQ-014 SHALL have o_bus_data output WORD_SIZE, the core write data.
REQ-015 SHALL have o_bus_we output 1, the core write enable.
REQ-016 SHALL have i_bus_rdata input WORD_SIZE, the core read data, registered with 1-cycle latency.
REQ-017 SHALL have i_bus_ready input 1, the core ready/idle indicator.

Function
REQ-018 The FSM SHALL have the states IDLE, WRITE, WAIT_BUSY, WAIT_DONE, READ0, READ1, READ2 and RSP.
REQ-019 o_req_ready SHALL be high only in IDLE.
REQ-020 On acceptance, the block SHALL capture mode, data and key internally and go to WRITE.
REQ-021 WRITE SHALL issue one write per cycle over 7 cycles:
- addr 0 with data part 1, addr 1 with data part 2;
- addr 2..5 with key parts 1..4;
- addr 6 with CTRL_ENC or CTRL_DEC per the captured mode.
REQ-022 After the addr-6 write, the FSM SHALL go to WAIT_BUSY.
REQ-023 Outside WRITE, o_bus_we SHALL be 0; o_bus_data SHALL be 0 except during writes.
REQ-024 WAIT_BUSY SHALL leave on i_bus_ready=0 to WAIT_DONE.
REQ-025 WAIT_DONE SHALL leave on i_bus_ready=1 to READ0.
REQ-026 READ0 SHALL drive addr 7.
REQ-027 READ1 SHALL drive addr 8 and capture i_bus_rdata as result part 1.
REQ-028 READ2 SHALL capture i_bus_rdata as result part 2, then go to RSP.
REQ-029 A cycle counter SHALL clear on entry to WAIT_BUSY and WAIT_DONE and increment each cycle in those states.
REQ-030 When the counter reaches TIMEOUT, the FSM SHALL go to RSP with o_rsp_err=1 and o_rsp_data=0.
REQ-031 RSP SHALL assert o_rsp_valid with data stable until i_rsp_ready, then return to IDLE.
REQ-032 If i_rsp_ready is already high on RSP entry, the response SHALL complete in 1 cycle.
REQ-033 o_rsp_err SHALL clear on return to IDLE.
REQ-034 A request arriving while not in IDLE SHALL NOT be accepted and SHALL be held by the requester.
REQ-035 The counter SHALL saturate and never wrap.
REQ-036 Latency from acceptance to o_rsp_valid SHALL be 7 write cycles + WAIT_BUSY + WAIT_DONE + 3 read cycles, with no idle gaps.
REQ-037 Address order SHALL be fixed; data and key SHALL NOT be reordered.

Reset
REQ-038 While i_rst is high at a clock edge, the state SHALL be IDLE and the counter 0.
REQ-039 Reset values: o_req_ready=1 in the cycle after reset; o_rsp_valid=0, o_rsp_err=0, o_rsp_data=0, o_bus_we=0, o_bus_addr=0, o_bus_data=0.
REQ-040 Captured registers SHALL be cleared by reset.
REQ-041 Reset mid-operation SHALL abandon the transaction with no further bus writes; core reset is the integrator's responsibility.

Structure
REQ-042 Shared package tea_pkg SHALL hold:
- register address constants 0..8;
- CTRL_NONE=0, CTRL_ENC=1, CTRL_DEC=2;
- the state enum typedef;
- the WORD_SIZE default.
REQ-043 The block SHALL be a single module with no sub-module; the bench instantiates tea_host_ctrl with the TEA core or a behavioural core model.

Verification
REQ-044 Encrypt: key 0, data 0, mode 0 -> bus writes addr 0..6 in consecutive cycles; response {0x94BAA940, 0x41EA3A0A}; o_rsp_err=0.
REQ-045 Round trip: decrypt the previous response with key 0 -> o_rsp_data=0.
REQ-046 Backpressure: i_rsp_ready low for 5 cycles -> o_rsp_valid and data stable; o_req_ready=0 throughout.
REQ-047 Timeout: model holds i_bus_ready=1 forever -> after TIMEOUT cycles, o_rsp_valid=1, o_rsp_err=1, o_rsp_data=0.
REQ-048 Reset on the 4th write cycle -> next cycle o_bus_we=0, o_req_ready=1; a following request completes correctly.
REQ-049 Back-to-back requests with i_req_valid held high -> second accepted the cycle after the first response is taken.
